status_flag_unit: RTL and testbench

- 6502 processor status register (P) sitting directly downstream of ALU_COMPLETE.
- Captures N/Z/C/V from the ALU result and carry/overflow outputs.
- Executes the flag instructions (SEC/CLC/SEI/CLI/SED/CLD/CLV), BIT, PLP/RTI restore and interrupt entry.
- Feeds the carry back to the ALU cin input and provides branch-condition evaluation and the PHP/BRK push image.

---
 rtl/status_flag_unit_if.sv | 32 +++
 rtl/status_flag_unit.sv | 119 +++++++++++
 tb/tb_status_flag_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/status_flag_unit_if.sv
// Status-register side-band bundle between the controller/ALU and the P register.
interface status_flag_unit_if;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic       alu_vout;
  logic [7:0] data_in;
  logic [3:0] flag_we;
  logic       bit_op;
  logic [2:0] flag_op;
  logic       load_p;
  logic       irq_entry;
  logic       push_brk;
  logic [2:0] cond_sel;
  logic [7:0] p_reg;
  logic [7:0] p_push;
  logic       c_flag;
  logic       branch_taken;

  // Controller side: drives the update requests, observes the flags.
  modport master (
    output alu_out, alu_cout, alu_vout, data_in, flag_we, bit_op, flag_op,
    output load_p, irq_entry, push_brk, cond_sel,
    input  p_reg, p_push, c_flag, branch_taken
  );

  // Status register side.
  modport slave (
    input  alu_out, alu_cout, alu_vout, data_in, flag_we, bit_op, flag_op,
    input  load_p, irq_entry, push_brk, cond_sel,
    output p_reg, p_push, c_flag, branch_taken
  );
endinterface

// File: rtl/status_flag_unit.sv
// 6502 processor status register (P): ALU flag capture, flag instructions, BIT,
// PLP/RTI restore, interrupt entry, carry feedback and branch evaluation.
module status_flag_unit #(
  parameter logic [7:0] RESET_P = 8'h34
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic                 en,
  status_flag_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    FlagNone = 3'd0,
    FlagSec  = 3'd1,
    FlagClc  = 3'd2,
    FlagSei  = 3'd3,
    FlagCli  = 3'd4,
    FlagSed  = 3'd5,
    FlagCld  = 3'd6,
    FlagClv  = 3'd7
  } flag_op_e;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;

  flag_op_e op;
  logic     alu_zero;

  assign op       = flag_op_e'(bus.flag_op);
  assign alu_zero = (bus.alu_out == 8'h00);

  // Next-state per flag; later assignments carry higher priority.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (en) begin
      // ALU capture
      if (bus.flag_we[3]) n_d = bus.alu_out[7];
      if (bus.flag_we[2]) z_d = alu_zero;
      if (bus.flag_we[1]) c_d = bus.alu_cout;
      if (bus.flag_we[0]) v_d = bus.alu_vout;
      // BIT takes N/V from memory; Z comes from the AND result on alu_out
      if (bus.bit_op) begin
        n_d = bus.data_in[7];
        v_d = bus.data_in[6];
        z_d = alu_zero;
      end
      // Explicit flag instructions
      unique case (op)
        FlagSec: c_d = 1'b1;
        FlagClc: c_d = 1'b0;
        FlagSei: i_d = 1'b1;
        FlagCli: i_d = 1'b0;
        FlagSed: d_d = 1'b1;
        FlagCld: d_d = 1'b0;
        FlagClv: v_d = 1'b0;
        default: ;
      endcase
      // PLP / RTI restore; bits 5:4 of data_in are not stored
      if (bus.load_p) begin
        n_d = bus.data_in[7];
        v_d = bus.data_in[6];
        d_d = bus.data_in[3];
        i_d = bus.data_in[2];
        z_d = bus.data_in[1];
        c_d = bus.data_in[0];
      end
      // Interrupt entry masks further IRQs, overriding a concurrent restore
      if (bus.irq_entry) i_d = 1'b1;
    end
  end

  // Flag flops with synchronous active-low reset that ignores en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_q <= RESET_P[7];
      v_q <= RESET_P[6];
      d_q <= RESET_P[3];
      i_q <= RESET_P[2];
      z_q <= RESET_P[1];
      c_q <= RESET_P[0];
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  // Register images and carry feedback.
  always_comb begin
    bus.p_reg  = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
    bus.p_push = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
    bus.c_flag = c_q;
  end

  // Branch condition on current flags.
  always_comb begin
    bus.branch_taken = 1'b0;
    unique case (bus.cond_sel)
      3'd0: bus.branch_taken = !n_q;
      3'd1: bus.branch_taken = n_q;
      3'd2: bus.branch_taken = !v_q;
      3'd3: bus.branch_taken = v_q;
      3'd4: bus.branch_taken = !c_q;
      3'd5: bus.branch_taken = c_q;
      3'd6: bus.branch_taken = !z_q;
      3'd7: bus.branch_taken = z_q;
      default: bus.branch_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed plan with literal expectations, then
// random traffic, all outputs compared against a byte-level model every cycle.
module tb_status_flag_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [7:0] mdl_p;

  status_flag_unit_if bus ();

  status_flag_unit #(.RESET_P(8'h34)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: P as a byte; apply rules from lowest to highest priority so later
  // writes win. Bits 5:4 always read as 1.
  function automatic logic [7:0] model_next(input logic [7:0] p);
    logic [7:0] r;
    r = p;
    if (!rst_n) return 8'h34 | 8'h30;
    if (!en) return p;
    if (bus.flag_we[3]) r[7] = bus.alu_out[7];
    if (bus.flag_we[2]) r[1] = (bus.alu_out == 0);
    if (bus.flag_we[1]) r[0] = bus.alu_cout;
    if (bus.flag_we[0]) r[6] = bus.alu_vout;
    if (bus.bit_op) begin
      r[7] = bus.data_in[7];
      r[6] = bus.data_in[6];
      r[1] = (bus.alu_out == 0);
    end
    // flag_op n: odd = set, even = clear; pairs map to C, I, D, then CLV
    case (bus.flag_op)
      3'd1: r[0] = 1'b1;
      3'd2: r[0] = 1'b0;
      3'd3: r[2] = 1'b1;
      3'd4: r[2] = 1'b0;
      3'd5: r[3] = 1'b1;
      3'd6: r[3] = 1'b0;
      3'd7: r[6] = 1'b0;
      default: ;
    endcase
    if (bus.load_p) r = bus.data_in;
    if (bus.irq_entry) r[2] = 1'b1;
    return r | 8'h30;
  endfunction

  // Branch: sel[2:1] picks N, V, C, Z; sel[0] says whether the flag must be set.
  function automatic logic model_branch(input logic [7:0] p, input logic [2:0] sel);
    int pos [4] = '{7, 6, 0, 1};
    return p[pos[sel[2:1]]] == sel[0];
  endfunction

  always @(posedge clk) mdl_p = model_next(mdl_p);

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check8("p_reg", bus.p_reg, mdl_p);
      check8("p_push", bus.p_push, {mdl_p[7:6], 1'b1, bus.push_brk, mdl_p[3:0]});
      check8("c_flag", {7'd0, bus.c_flag}, {7'd0, mdl_p[0]});
      check8("branch", {7'd0, bus.branch_taken},
             {7'd0, model_branch(mdl_p, bus.cond_sel)});
    end
  end

  task automatic idle();
    en            = 1'b1;
    bus.alu_out   = 8'h01;
    bus.alu_cout  = 1'b0;
    bus.alu_vout  = 1'b0;
    bus.data_in   = 8'h00;
    bus.flag_we   = 4'b0000;
    bus.bit_op    = 1'b0;
    bus.flag_op   = 3'd0;
    bus.load_p    = 1'b0;
    bus.irq_entry = 1'b0;
    bus.push_brk  = 1'b0;
    bus.cond_sel  = 3'd0;
  endtask

  // Inputs are set before calling; advance one edge, return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
  endtask

  localparam logic [2:0] OpSec = 3'd1, OpClc = 3'd2, OpCli = 3'd4, OpSed = 3'd5;
  localparam logic [7:0] ExpBranch = 8'b0110_0110;  // cond_sel 0..7, LSB first

  initial begin
    idle();
    rst_n = 1'b0;
    en    = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // Reset
    do_reset();
    check8("reset_p", bus.p_reg, 8'h34);
    check8("reset_c", {7'd0, bus.c_flag}, 8'h00);
    tick();
    check8("reset_idle", bus.p_reg, 8'h34);

    // ALU capture
    bus.alu_out = 8'h80; bus.alu_cout = 1'b1; bus.alu_vout = 1'b1; bus.flag_we = 4'hF;
    tick();
    check8("alu_neg", bus.p_reg, 8'hF5);
    bus.alu_out = 8'h00; bus.flag_we = 4'hF;
    tick();
    check8("alu_zero", bus.p_reg, 8'h36);

    // Flag instructions
    do_reset();
    bus.flag_op = OpCli; tick(); check8("cli", bus.p_reg, 8'h30);
    bus.flag_op = OpSed; tick(); check8("sed", bus.p_reg, 8'h38);
    bus.flag_op = OpSec; tick(); check8("sec", bus.p_reg, 8'h39);
    bus.flag_op = OpClc; tick(); check8("clc", bus.p_reg, 8'h38);
    en = 1'b0; bus.flag_op = OpSec; tick(); check8("sec_no_en", bus.p_reg, 8'h38);

    // BIT and restore
    bus.data_in = 8'hC0; bus.alu_out = 8'h00; bus.bit_op = 1'b1; bus.flag_we = 4'b0100;
    tick();
    check8("bit", bus.p_reg, 8'hFA);
    bus.load_p = 1'b1; bus.data_in = 8'h00; tick();
    check8("plp_zero", bus.p_reg, 8'h30);
    bus.load_p = 1'b1; bus.irq_entry = 1'b1; bus.data_in = 8'hCB; tick();
    check8("plp_irq", bus.p_reg, 8'hFF);
    bus.push_brk = 1'b0; #1; check8("push_b0", bus.p_push, 8'hEF);
    bus.push_brk = 1'b1; #1; check8("push_b1", bus.p_push, 8'hFF);
    bus.push_brk = 1'b0;

    // Priority
    bus.flag_op = OpClc; bus.flag_we = 4'b0010; bus.alu_cout = 1'b1; tick();
    check8("clc_over_alu", {7'd0, bus.c_flag}, 8'h00);
    bus.flag_op = OpSec; bus.flag_we = 4'b0010; bus.alu_cout = 1'b0; tick();
    check8("sec_over_alu", {7'd0, bus.c_flag}, 8'h01);
    rst_n = 1'b0; bus.load_p = 1'b1; bus.data_in = 8'hFF; tick();
    check8("rst_over_load", bus.p_reg, 8'h34);

    // Branch sweep with N=1, C=1, V=0, Z=0
    bus.load_p = 1'b1; bus.data_in = 8'h81; tick();
    check8("branch_p", bus.p_reg, 8'hB1);
    for (int s = 0; s < 8; s++) begin
      bus.cond_sel = 3'(s);
      #1;
      check8($sformatf("branch_%0d", s), {7'd0, bus.branch_taken}, {7'd0, ExpBranch[s]});
    end
    bus.cond_sel = 3'd0;

    // Random traffic; the compare process checks every cycle
    for (int k = 0; k < 3000; k++) begin
      rst_n         = ($urandom_range(0, 60) != 0);
      en            = ($urandom_range(0, 4) != 0);
      bus.alu_out   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      bus.alu_cout  = 1'($urandom);
      bus.alu_vout  = 1'($urandom);
      bus.data_in   = 8'($urandom);
      bus.flag_we   = 4'($urandom);
      bus.bit_op    = ($urandom_range(0, 5) == 0);
      bus.flag_op   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
      bus.load_p    = ($urandom_range(0, 7) == 0);
      bus.irq_entry = ($urandom_range(0, 7) == 0);
      bus.push_brk  = 1'($urandom);
      bus.cond_sel  = 3'($urandom);
      @(posedge clk);
      #1;
    end

    idle();
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
